fifo_ptr_ctrl: RTL and testbench

//  Pointer/flag controller for the SpaceWire 9-bit FIFO storage array (mem_data).

---
 rtl/fifo_ptr_ctrl.sv | 90 +++++++++
 tb/tb_fifo_ptr_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for the 9-bit link FIFO storage array.
// The array writes every cycle, so one slot is always kept free.
module fifo_ptr_ctrl #(
  parameter int AWIDTH   = 6,
  parameter int AF_LEVEL = 56
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [AWIDTH-1:0] wr_ptr,
  output logic [AWIDTH-1:0] rd_ptr,
  output logic [AWIDTH-1:0] count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              rd_valid,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AWIDTH-1:0] FULL_LVL = '1;
  localparam logic [AWIDTH-1:0] AF_LVL   =
    AWIDTH'(AF_LEVEL);

  logic              push;
  logic              pop;
  logic [AWIDTH-1:0] cnt_nxt;

  // accept only against the registered flags
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  // next occupancy; simultaneous push and pop cancel
  always_comb begin
    cnt_nxt = count;
    unique case ({push, pop})
      2'b10:   cnt_nxt = count + 1'b1;
      2'b01:   cnt_nxt = count - 1'b1;
      default: cnt_nxt = count;
    endcase
  end

  // pointers advance only on accepted operations
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // count and level flags, all from the next count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= cnt_nxt;
      empty       <= (cnt_nxt == '0);
      full        <= (cnt_nxt == FULL_LVL);
      almost_full <= (cnt_nxt >= AF_LVL);
    end
  end

  // read data from the array lands one cycle after a pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_valid <= 1'b0;
    else        rd_valid <= pop;
  end

  // sticky errors; a new error beats a clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full)       overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
      if (rd_en & empty)      underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl with a behavioural
// model of the always-writing storage array.
module tb_fifo_ptr_ctrl;

  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          rd_en;
  logic          clr_err;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          rd_valid;
  logic          overflow;
  logic          underflow;

  logic [8:0]    data_in;
  logic [8:0]    data_out;
  logic [8:0]    mem [2**AW];

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] q [$];

  always #5 clock = ~clock;

  fifo_ptr_ctrl #(.AWIDTH(AW), .AF_LEVEL(56)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .rd_valid    (rd_valid),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // storage array: write every clock, registered read
  always @(posedge clock) begin
    mem[wr_ptr] <= data_in;
    data_out    <= mem[rd_ptr];
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    data_in = '0;
    reset   = 1'b0;
    step();
    reset   = 1'b1;
    q.delete();
  endtask

  task automatic check_reset_state(input string t);
    check({t, "_wr_ptr"}, wr_ptr, 0);
    check({t, "_rd_ptr"}, rd_ptr, 0);
    check({t, "_count"}, count, 0);
    check({t, "_empty"}, empty, 1);
    check({t, "_full"}, full, 0);
    check({t, "_af"}, almost_full, 0);
    check({t, "_rd_valid"}, rd_valid, 0);
    check({t, "_ovf"}, overflow, 0);
    check({t, "_unf"}, underflow, 0);
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      data_in = 9'(i + 9'h40);
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    // watchdog: never hang
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    do_reset();
    check_reset_state("rst");

    // 1 fill to capacity then overflow
    for (int k = 1; k <= 63; k++) begin
      wr_en   = 1'b1;
      data_in = 9'(k);
      step();
      check("fill_count", count, k);
      check("fill_af", almost_full, (k >= 56));
      check("fill_full", full, (k == 63));
    end
    check("fill_wr_ptr", wr_ptr, 63);
    check("fill_rd_ptr", rd_ptr, 0);
    check("fill_ovf0", overflow, 0);
    step();
    check("ovf_set", overflow, 1);
    check("ovf_wr_ptr", wr_ptr, 63);
    check("ovf_count", count, 63);
    wr_en = 1'b0;
    step();
    check("ovf_sticky", overflow, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_clr", overflow, 0);

    // 2 one-cycle read latency
    do_reset();
    wr_en   = 1'b1;
    data_in = 9'h1AB;
    step();
    wr_en   = 1'b0;
    data_in = 9'h055;
    check("lat_empty", empty, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("lat_valid", rd_valid, 1);
    check("lat_data", data_out, 9'h1AB);
    check("lat_empty2", empty, 1);
    step();
    check("lat_valid_off", rd_valid, 0);
    check("lat_unf", underflow, 0);

    // 3 simultaneous push and pop at count 5
    do_reset();
    push_n(5);
    check("sim_count0", count, 5);
    wr_en = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("sim_count", count, 5);
    check("sim_wr_ptr", wr_ptr, 15);
    check("sim_rd_ptr", rd_ptr, 10);

    // 4 wrap with random data, order preserved
    do_reset();
    for (int i = 0; i <= 201; i++) begin
      wr_en   = (i < 201);
      rd_en   = (i > 0);
      data_in = 9'($urandom_range(0, 511));
      if (wr_en) q.push_back(data_in);
      step();
      check("wrap_valid", rd_valid, (i > 0));
      if (i > 0) begin
        if (q.size() == 0)
          check("wrap_q", 0, 1);
        else
          check("wrap_data", data_out, q.pop_front());
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("wrap_wr_ptr", wr_ptr, 201 % 64);
    check("wrap_rd_ptr", rd_ptr, 201 % 64);
    check("wrap_empty", empty, 1);
    check("wrap_unf", underflow, 0);

    // 5 underflow, clear, set-wins
    do_reset();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("unf_set", underflow, 1);
    check("unf_valid", rd_valid, 0);
    check("unf_rd_ptr", rd_ptr, 0);
    check("unf_count", count, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("unf_clr", underflow, 0);
    clr_err = 1'b1;
    rd_en   = 1'b1;
    step();
    clr_err = 1'b0;
    rd_en   = 1'b0;
    check("unf_set_wins", underflow, 1);

    // 6 asynchronous reset mid-fill
    do_reset();
    push_n(20);
    check("mid_count", count, 20);
    #3;
    reset = 1'b0;
    #1;
    check_reset_state("mid");
    @(posedge clock);
    #1;
    reset = 1'b1;
    check("mid_wr_ptr0", wr_ptr, 0);
    wr_en   = 1'b1;
    data_in = 9'h0C3;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    check("mid_wr_ptr1", wr_ptr, 1);
    check("mid_count1", count, 1);
    step();
    rd_en = 1'b0;
    check("mid_valid", rd_valid, 1);
    check("mid_data", data_out, 9'h0C3);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
